d_mem_arbiter: RTL
==================

// Module: d_mem_arbiter
// PURPOSE
//   Shares the single-port byte-addressed data memory between two requesters:
//   r0 = pipeline load/store unit, r1 = secondary master (loader/debug/DMA).
//   Sequences one access at a time, drives the memory's addr/wdata/func3/rd_en/wr_en,
//   registers the read result and returns it with a one-cycle valid pulse.
// PARAMETERS
//   ADDR_W     11  byte-address width (memory depth 2**ADDR_W bytes)
//   DATA_W     32  data width of wdata/rdata
//   PRIO_FIXED 0   0 = round-robin between r0/r1; 1 = r0 always wins ties
// PORTS
//   clk         in   1       clock; all state updates on rising edge
//   rst         in   1       synchronous, active-high reset
//   rN_req      in   1       N=0,1: access request; held with fields until rN_gnt
//   rN_we       in   1       1 = store, 0 = load
//   rN_addr     in   ADDR_W  byte address
//   rN_wdata    in   DATA_W  store data (byte/half in low bits)
//   rN_func3    in   3       RV32 load/store func3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   rN_gnt      out  1       request accepted (one-cycle pulse)
//   rN_rvalid   out  1       access complete (one-cycle pulse)
//   rN_rdata    out  DATA_W  load result, valid with rN_rvalid; 0 for stores
//   rN_err      out  1       access rejected, valid with rN_rvalid
//   mem_addr    out  ADDR_W  to memory addr
//   mem_wdata   out  DATA_W  to memory wdata
//   mem_func3   out  3       to memory func3
//   mem_rd_en   out  1       to memory rd_en
//   mem_wr_en   out  1       to memory wr_en (memory writes on falling edge)
//   mem_rdata   in   DATA_W  combinational read data from memory
// BEHAVIOUR
//   - FSM IDLE -> ACCESS -> RESP -> IDLE; one access in flight; 3 cycles/access.
//   - IDLE: if any rN_req, pick winner, latch we/addr/wdata/func3/owner -> ACCESS.
//     No request: stay IDLE.
//   - Arbitration: single requester wins. Both: PRIO_FIXED=1 -> r0; else the one not
//     granted last. last_owner resets to 1, so r0 wins the first tie.
//   - ACCESS: rN_gnt=1 for owner only; mem_* driven from latched regs;
//     mem_rd_en=!we_q, mem_wr_en=we_q (exactly one cycle). Load data captured from
//     mem_rdata at end of ACCESS; store -> rdata_q=0. Next: RESP.
//   - RESP: owner rN_rvalid=1 with rN_rdata=rdata_q, rN_err=err_q; update last_owner;
//     -> IDLE. Requester deasserts req the cycle after gnt unless issuing a new one.
//   - Latency: req sampled at edge t -> gnt during cycle t+1 -> rvalid during t+2.
//   - Outside ACCESS: mem_rd_en=mem_wr_en=0, mem_addr/wdata/func3=0.
//   - Non-owner outputs always 0; rdata only meaningful with rvalid.
//   - Undefined func3: forwarded unchanged (memory yields 0 / no write), err=0.
//   - Reset (any state): next state IDLE, all outputs 0, last_owner=1, latched regs 0.
//     mem_rd_en/mem_wr_en gated by !rst combinationally: no write in a reset cycle.
//   - Address wrap: no range check; addr+1..+3 wrap handled inside memory.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: in IDLE, latched access flagged misaligned if
//     (func3[1:0]==01 && addr[0]) || (func3[1:0]==10 && addr[1:0]!=0).
//     Misaligned: go IDLE -> RESP directly (skip ACCESS), gnt pulses in RESP with
//     rvalid, err=1, rdata=0, mem enables never asserted.
//   MISALIGN_TRAP_EN undefined: no check, rN_err tied 0, all accesses as-is.
// TESTING
//   1. mem[0x010..0x013]=EF BE AD DE; r0 LW 0x010 -> r0_gnt cycle 1,
//      r0_rvalid cycle 2, r0_rdata=0xDEADBEEF.
//   2. r1 SB 0x005 wdata 0x000000A5 -> then r1 LBU 0x005 rdata=0x000000A5;
//      LB 0x005 rdata=0xFFFFFFA5; SH 0x006 0x1234 then LHU 0x006 -> 0x00001234.
//   3. r0,r1 requesting back-to-back: PRIO_FIXED=0 gnt order r0,r1,r0,r1, one per 3
//      cycles; PRIO_FIXED=1 all r0 while r0_req high.
//   4. rst high during ACCESS of r0 SW 0x020 0xCAFEF00D -> mem_wr_en=0 that cycle,
//      mem[0x020..0x023] unchanged, next cycle IDLE, all outputs 0.
//   5. MISALIGN_TRAP_EN: r0 LW 0x002 -> r0_rvalid=1, r0_err=1, rdata=0, mem_rd_en
//      never 1; without macro same request -> normal access, err=0.
//   6. No requests 10 cycles -> state IDLE, all mem_* and rN_* outputs 0.

Source files
------------

// File: rtl/d_mem_arbiter_if.sv
// Bus between the data-memory arbiter, its two requesters and the single-port memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface d_mem_arbiter_if #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 32
);
   logic              r0_req;
   logic              r0_we;
   logic [ADDR_W-1:0] r0_addr;
   logic [DATA_W-1:0] r0_wdata;
   logic [2:0]        r0_func3;
   logic              r0_gnt;
   logic              r0_rvalid;
   logic [DATA_W-1:0] r0_rdata;
   logic              r0_err;

   logic              r1_req;
   logic              r1_we;
   logic [ADDR_W-1:0] r1_addr;
   logic [DATA_W-1:0] r1_wdata;
   logic [2:0]        r1_func3;
   logic              r1_gnt;
   logic              r1_rvalid;
   logic [DATA_W-1:0] r1_rdata;
   logic              r1_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [2:0]        mem_func3;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  r0_req, r0_we, r0_addr, r0_wdata, r0_func3,
      output r0_gnt, r0_rvalid, r0_rdata, r0_err,
      input  r1_req, r1_we, r1_addr, r1_wdata, r1_func3,
      output r1_gnt, r1_rvalid, r1_rdata, r1_err,
      output mem_addr, mem_wdata, mem_func3, mem_rd_en, mem_wr_en,
      input  mem_rdata
   );

   modport master (
      output r0_req, r0_we, r0_addr, r0_wdata, r0_func3,
      input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
      output r1_req, r1_we, r1_addr, r1_wdata, r1_func3,
      input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
      input  mem_addr, mem_wdata, mem_func3, mem_rd_en, mem_wr_en,
      output mem_rdata
   );
endinterface

// File: rtl/d_mem_arbiter.sv
// Two-requester arbiter for the single-port data memory: IDLE -> ACCESS -> RESP, one access in flight.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip ACCESS and respond with err=1.
module d_mem_arbiter #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int PRIO_FIXED = 0
) (
   input logic            clk,
   input logic            rst,
   d_mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   logic [1:0]        state;
   logic              owner_q;
   logic              last_owner;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [2:0]        func3_q;
   logic [DATA_W-1:0] rdata_q;

   logic              any_req;
   logic              pick_r1;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [2:0]        sel_func3;
   logic              in_access;
   logic              in_resp;
   logic              gnt_now;

`ifdef MISALIGN_TRAP_EN
   logic err_q;
   logic sel_mis;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
      return (size == 2'b01 && lsb[0]) || (size == 2'b10 && lsb != 2'b00);
   endfunction

   assign sel_mis = is_misaligned(sel_func3[1:0], sel_addr[1:0]);
`endif

   // Winner selection: a lone requester wins; on a tie the one not served last, unless fixed priority.
   always_comb begin
      any_req = bus.r0_req | bus.r1_req;
      if (bus.r0_req && bus.r1_req)
         pick_r1 = (PRIO_FIXED != 0) ? 1'b0 : ~last_owner;
      else
         pick_r1 = bus.r1_req;
      sel_we    = pick_r1 ? bus.r1_we    : bus.r0_we;
      sel_addr  = pick_r1 ? bus.r1_addr  : bus.r0_addr;
      sel_wdata = pick_r1 ? bus.r1_wdata : bus.r0_wdata;
      sel_func3 = pick_r1 ? bus.r1_func3 : bus.r0_func3;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner_q    <= 1'b0;
         last_owner <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         func3_q    <= '0;
         rdata_q    <= '0;
`ifdef MISALIGN_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner_q <= pick_r1;
                  we_q    <= sel_we;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  func3_q <= sel_func3;
                  rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
                  err_q   <= sel_mis;
                  state   <= sel_mis ? RESP : ACCESS;
`else
                  state   <= ACCESS;
`endif
               end
            end
            ACCESS: begin
               rdata_q <= we_q ? '0 : bus.mem_rdata;
               state   <= RESP;
            end
            RESP: begin
               last_owner <= owner_q;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Reset gates every output combinationally so a reset cycle can never write memory.
   assign in_access = (state == ACCESS) && !rst;
   assign in_resp   = (state == RESP) && !rst;
`ifdef MISALIGN_TRAP_EN
   assign gnt_now   = in_access || (in_resp && err_q);
   assign bus.r0_err = in_resp && !owner_q && err_q;
   assign bus.r1_err = in_resp &&  owner_q && err_q;
`else
   assign gnt_now   = in_access;
   assign bus.r0_err = 1'b0;
   assign bus.r1_err = 1'b0;
`endif

   assign bus.r0_gnt    = gnt_now && !owner_q;
   assign bus.r1_gnt    = gnt_now &&  owner_q;
   assign bus.r0_rvalid = in_resp && !owner_q;
   assign bus.r1_rvalid = in_resp &&  owner_q;
   assign bus.r0_rdata  = (in_resp && !owner_q) ? rdata_q : '0;
   assign bus.r1_rdata  = (in_resp &&  owner_q) ? rdata_q : '0;

   assign bus.mem_addr  = in_access ? addr_q  : '0;
   assign bus.mem_wdata = in_access ? wdata_q : '0;
   assign bus.mem_func3 = in_access ? func3_q : '0;
   assign bus.mem_rd_en = in_access && !we_q;
   assign bus.mem_wr_en = in_access &&  we_q;
endmodule
